demux_4: RTL and testbench

- Registered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 output mux.
- Routes one DATA_BITS word per cycle from a single upstream source to one of four downstream FIFOs, chosen by a 2-bit selector.
- Provides valid/ready backpressure toward the source, honours per-channel full flags from the FIFOs, and keeps per-channel delivered-word counters.

---
 rtl/demux_4.sv | 117 +++++++++++
 tb/tb_demux_4.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_4.sv
// Registered 1-to-4 demultiplexer feeding four downstream FIFOs, with valid/ready toward the
// source, a one-word hold register for stalls on a full channel, and per-channel word counters.
module demux_4 #(
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enb,
  input  logic [DATA_BITS-1:0] entrada,
  input  logic                 valid_in,
  input  logic [1:0]           selector,
  input  logic [3:0]           full,
  output logic                 ready_out,
  output logic [DATA_BITS-1:0] salida0,
  output logic [DATA_BITS-1:0] salida1,
  output logic [DATA_BITS-1:0] salida2,
  output logic [DATA_BITS-1:0] salida3,
  output logic                 push0,
  output logic                 push1,
  output logic                 push2,
  output logic                 push3,
  output logic [CNT_BITS-1:0]  cuenta0,
  output logic [CNT_BITS-1:0]  cuenta1,
  output logic [CNT_BITS-1:0]  cuenta2,
  output logic [CNT_BITS-1:0]  cuenta3
);

  typedef enum logic {StVacio, StEspera} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [1:0]           hold_sel_q, hold_sel_d;
  logic [3:0]           push_q, push_d;
  logic [DATA_BITS-1:0] salida_q [4];
  logic [CNT_BITS-1:0]  cuenta_q [4];

  logic                 deliver;
  logic [1:0]           del_sel;
  logic [DATA_BITS-1:0] del_data;

  assign ready_out = enb & reset_L & (state_q == StVacio);

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    deliver     = 1'b0;
    del_sel     = selector;
    del_data    = entrada;
    push_d      = 4'b0000;
    if (enb) begin
      unique case (state_q)
        StVacio: begin
          if (valid_in) begin
            if (!full[selector]) begin
              deliver = 1'b1;
            end else begin
              hold_data_d = entrada;
              hold_sel_d  = selector;
              state_d     = StEspera;
            end
          end
        end
        StEspera: begin
          // Only the held word's own channel can release the stall.
          del_sel  = hold_sel_q;
          del_data = hold_data_q;
          if (!full[hold_sel_q]) begin
            deliver = 1'b1;
            state_d = StVacio;
          end
        end
        default: state_d = StVacio;
      endcase
    end
    if (deliver) push_d[del_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StVacio;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      push_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        salida_q[i] <= '0;
        cuenta_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      push_q      <= push_d;
      for (int i = 0; i < 4; i++) begin
        if (push_d[i]) begin
          salida_q[i] <= del_data;
          cuenta_q[i] <= cuenta_q[i] + CNT_BITS'(1);
        end
      end
    end
  end

  assign salida0 = salida_q[0];
  assign salida1 = salida_q[1];
  assign salida2 = salida_q[2];
  assign salida3 = salida_q[3];
  assign push0   = push_q[0];
  assign push1   = push_q[1];
  assign push2   = push_q[2];
  assign push3   = push_q[3];
  assign cuenta0 = cuenta_q[0];
  assign cuenta1 = cuenta_q[1];
  assign cuenta2 = cuenta_q[2];
  assign cuenta3 = cuenta_q[3];

endmodule

// File: tb/tb_demux_4.sv
// Self-checking bench for demux_4: directed scenarios plus randomized traffic against a
// transaction-level model (pending word, per-channel last value and delivery count).
module tb_demux_4;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk, reset_L, enb, valid_in;
  logic [DW-1:0] entrada;
  logic [1:0]    selector;
  logic [3:0]    full;
  logic          ready_out;
  logic [DW-1:0] salida0, salida1, salida2, salida3;
  logic          push0, push1, push2, push3;
  logic [CW-1:0] cuenta0, cuenta1, cuenta2, cuenta3;

  demux_4 #(.DATA_BITS(DW), .CNT_BITS(CW)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .entrada(entrada), .valid_in(valid_in),
    .selector(selector), .full(full), .ready_out(ready_out),
    .salida0(salida0), .salida1(salida1), .salida2(salida2), .salida3(salida3),
    .push0(push0), .push1(push1), .push2(push2), .push3(push3),
    .cuenta0(cuenta0), .cuenta1(cuenta1), .cuenta2(cuenta2), .cuenta3(cuenta3)
  );

  logic [3:0]    push_v;
  logic [DW-1:0] sal_v [4];
  logic [CW-1:0] cnt_v [4];
  assign push_v = {push3, push2, push1, push0};
  assign sal_v[0] = salida0;
  assign sal_v[1] = salida1;
  assign sal_v[2] = salida2;
  assign sal_v[3] = salida3;
  assign cnt_v[0] = cuenta0;
  assign cnt_v[1] = cuenta1;
  assign cnt_v[2] = cuenta2;
  assign cnt_v[3] = cuenta3;

  int total = 0;
  int bad = 0;

  // Reference model: a source word is either delivered straight away or parked as pending.
  bit            m_pend;
  logic [DW-1:0] m_pdata;
  int            m_psel;
  logic [3:0]    m_push;
  logic [DW-1:0] m_sal [4];
  int            m_cnt [4];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_pend = 0; m_pdata = '0; m_psel = 0; m_push = '0;
    for (int i = 0; i < 4; i++) begin
      m_sal[i] = '0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_deliver(input int ch, input logic [DW-1:0] d, inout logic [3:0] np);
    np[ch]    = 1'b1;
    m_sal[ch] = d;
    m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CW);
  endtask

  task automatic model_edge();
    logic [3:0] np;
    np = '0;
    if (!reset_L) begin
      model_reset();
      return;
    end
    if (enb) begin
      if (!m_pend) begin
        if (valid_in) begin
          if (!full[selector]) model_deliver(int'(selector), entrada, np);
          else begin
            m_pend = 1; m_pdata = entrada; m_psel = int'(selector);
          end
        end
      end else if (!full[m_psel]) begin
        model_deliver(m_psel, m_pdata, np);
        m_pend = 0;
      end
    end
    m_push = np;
  endtask

  function automatic logic exp_ready();
    return enb && reset_L && !m_pend;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_L = 0; enb = 0; valid_in = 0; entrada = '0; selector = '0; full = '0;
    model_reset();
    tick();
    tick();
    total++;
    if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_out); end
    total++;
    if (push_v !== 4'b0000) begin bad++; $display("FAIL reset_push got=%b want=0000", push_v); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sal_v[i] !== '0 || cnt_v[i] !== '0) begin
        bad++;
        $display("FAIL reset_ch%0d salida=%h cuenta=%0d want 0/0", i, sal_v[i], cnt_v[i]);
      end
    end
    reset_L = 1; enb = 1;
    #1;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready_out); end
  endtask

  task automatic test_pass_through();
    full = 4'b0000; valid_in = 1; entrada = 4'hA; selector = 2'd2;
    tick();
    total++;
    if (push_v !== 4'b0100 || salida2 !== 4'hA || cuenta2 !== 8'd1) begin
      bad++;
      $display("FAIL pass_ch2 push=%b salida2=%h cuenta2=%0d want 0100/a/1", push_v, salida2, cuenta2);
    end
    entrada = 4'h5; selector = 2'd0;
    #1;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b want=1", ready_out); end
    tick();
    total++;
    if (push_v !== 4'b0001 || salida0 !== 4'h5 || cuenta0 !== 8'd1 || salida2 !== 4'hA) begin
      bad++;
      $display("FAIL pass_ch0 push=%b salida0=%h cuenta0=%0d salida2=%h want 0001/5/1/a",
               push_v, salida0, cuenta0, salida2);
    end
    valid_in = 0;
    tick();
    total++;
    if (push_v !== 4'b0000) begin bad++; $display("FAIL pass_idle push=%b want=0000", push_v); end
  endtask

  task automatic test_stall();
    full = 4'b0010; valid_in = 1; entrada = 4'h7; selector = 2'd1;
    tick();
    valid_in = 0;
    total++;
    if (push_v !== 4'b0000 || ready_out !== 1'b0) begin
      bad++; $display("FAIL stall_enter push=%b ready=%b want 0000/0", push_v, ready_out);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (push_v !== 4'b0000 || ready_out !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d push=%b ready=%b want 0000/0", k, push_v, ready_out);
      end
    end
    full = 4'b0000;
    tick();
    total++;
    if (push_v !== 4'b0010 || salida1 !== 4'h7 || cuenta1 !== 8'd1 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL stall_release push=%b salida1=%h cuenta1=%0d ready=%b want 0010/7/1/1",
               push_v, salida1, cuenta1, ready_out);
    end
  endtask

  task automatic test_isolation();
    logic [CW-1:0] c3;
    c3 = cuenta3;
    full = 4'b0010; valid_in = 1; entrada = 4'h9; selector = 2'd1;
    tick();
    entrada = 4'h3; selector = 2'd3;
    for (int k = 0; k < 4; k++) begin
      full = 4'($urandom) | 4'b0010;
      tick();
      total++;
      if (push_v !== 4'b0000 || ready_out !== 1'b0 || cuenta3 !== c3) begin
        bad++;
        $display("FAIL isolation%0d push=%b ready=%b cuenta3=%0d want 0000/0/%0d",
                 k, push_v, ready_out, cuenta3, c3);
      end
    end
    valid_in = 0; full = 4'b0000;
    tick();
    total++;
    if (push_v !== 4'b0010 || salida1 !== 4'h9) begin
      bad++; $display("FAIL isolation_release push=%b salida1=%h want 0010/9", push_v, salida1);
    end
    tick();
    total++;
    if (push_v !== 4'b0000 || cuenta3 !== c3) begin
      bad++; $display("FAIL isolation_after push=%b cuenta3=%0d want 0000/%0d", push_v, cuenta3, c3);
    end
  endtask

  task automatic test_enable_freeze();
    full = 4'b0010; valid_in = 1; entrada = 4'hE; selector = 2'd1;
    tick();
    valid_in = 0; full = 4'b0000; enb = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (push_v !== 4'b0000 || ready_out !== 1'b0) begin
        bad++; $display("FAIL freeze%0d push=%b ready=%b want 0000/0", k, push_v, ready_out);
      end
    end
    enb = 1;
    tick();
    total++;
    if (push_v !== 4'b0010 || salida1 !== 4'hE) begin
      bad++; $display("FAIL freeze_resume push=%b salida1=%h want 0010/e", push_v, salida1);
    end
  endtask

  task automatic test_reset_mid();
    full = 4'b0010; valid_in = 1; entrada = 4'hC; selector = 2'd1;
    tick();
    valid_in = 0;
    #3;
    reset_L = 0;
    model_reset();
    #1;
    total++;
    if (push_v !== 4'b0000 || ready_out !== 1'b0 || salida1 !== '0 || cuenta1 !== '0) begin
      bad++;
      $display("FAIL async_reset push=%b ready=%b salida1=%h cuenta1=%0d want 0000/0/0/0",
               push_v, ready_out, salida1, cuenta1);
    end
    tick();
    #3;
    reset_L = 1; full = 4'b0000;
    #1;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b want=1", ready_out); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (push_v !== 4'b0000 || salida1 !== '0) begin
        bad++; $display("FAIL reset_mid_nopush%0d push=%b salida1=%h want 0000/0", k, push_v, salida1);
      end
    end
  endtask

  task automatic test_counter_wrap();
    reset_L = 0;
    tick();
    reset_L = 1; enb = 1; full = 4'b0000; valid_in = 1; selector = 2'd3;
    for (int k = 1; k <= 257; k++) begin
      entrada = 4'($urandom);
      tick();
      if (k == 255 || k == 256) begin
        total++;
        if (cuenta3 !== CW'(k % 256)) begin
          bad++; $display("FAIL wrap_at%0d cuenta3=%0d want %0d", k, cuenta3, k % 256);
        end
      end
    end
    valid_in = 0;
    tick();
    total++;
    if (cuenta3 !== 8'd1 || cuenta0 !== '0 || cuenta1 !== '0 || cuenta2 !== '0) begin
      bad++;
      $display("FAIL wrap_final cuenta=%0d/%0d/%0d/%0d want 0/0/0/1", cuenta0, cuenta1, cuenta2,
               cuenta3);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset_L  = ($urandom_range(0, 79) != 0);
      enb      = ($urandom_range(0, 9) != 0);
      valid_in = ($urandom_range(0, 3) != 0);
      entrada  = 4'($urandom);
      selector = 2'($urandom);
      full     = 4'($urandom) & 4'($urandom);
      #1;
      total++;
      if (ready_out !== exp_ready()) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", k, ready_out, exp_ready());
      end
      tick();
      total++;
      if (push_v !== m_push) begin
        bad++; $display("FAIL rand_push cyc=%0d got=%b want=%b", k, push_v, m_push);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sal_v[i] !== m_sal[i] || cnt_v[i] !== CW'(m_cnt[i])) begin
          bad++;
          $display("FAIL rand_ch%0d cyc=%0d salida=%h cuenta=%0d want %h/%0d", i, k, sal_v[i],
                   cnt_v[i], m_sal[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall();
    test_isolation();
    test_enable_freeze();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
